// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl: assembles coded symbol pairs into one decoder frame,
// pulses the decoder clear, waits out the decode latency, then holds the result.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   sym_valid/sym_ready      upstream pair handshake
//   sym_data[1:0]            coded pair, [1] transmitted first
//   sym_last                 final pair of a (possibly short) frame
//   dec_dat[2N-1:0]          frame to decoder dat
//   dec_start                decoder ready
//   dec_reset                decoder active-low reset
//   dec_out[N-1:0]           decoder result
//   out_valid/out_ready      downstream handshake
//   out_data[N-1:0]          decoded bits, [N-1] first
//   out_len                  number of meaningful bits
//   busy                     high outside FILL
//   frame_cnt[15:0]          frames delivered, wrapping
module viterbi_frame_ctrl #(
   parameter  int N_BITS  = 7,
   parameter  int DEC_LAT = 8,
   localparam int DW      = 2 * N_BITS,
   localparam int LW      = $clog2(N_BITS + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sym_valid,
   input  logic [1:0]        sym_data,
   input  logic              sym_last,
   output logic              sym_ready,
   output logic [DW-1:0]     dec_dat,
   output logic              dec_start,
   output logic              dec_reset,
   input  logic [N_BITS-1:0] dec_out,
   output logic              out_valid,
   output logic [N_BITS-1:0] out_data,
   output logic [LW-1:0]     out_len,
   input  logic              out_ready,
   output logic              busy,
   output logic [15:0]       frame_cnt
);

   localparam int CW = (DEC_LAT > 1) ? $clog2(DEC_LAT) : 1;
   localparam logic [CW-1:0] LAT_END   = CW'(DEC_LAT - 1);
   localparam logic [LW-1:0] LAST_PAIR = LW'(N_BITS - 1);

   typedef enum logic [1:0] {
      S_FILL,
      S_CLR,
      S_WAIT,
      S_OUT
   } state_t;

   state_t            state_q, state_d;
   logic [DW-1:0]     dat_q, dat_d;
   logic [LW-1:0]     cnt_q, cnt_d;
   logic [CW-1:0]     lat_q, lat_d;
   logic [N_BITS-1:0] odata_q, odata_d;
   logic [LW-1:0]     olen_q, olen_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic              dec_reset_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_FILL;
         dat_q       <= '0;
         cnt_q       <= '0;
         lat_q       <= '0;
         odata_q     <= '0;
         olen_q      <= '0;
         frame_cnt_q <= '0;
         dec_reset_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         dat_q       <= dat_d;
         cnt_q       <= cnt_d;
         lat_q       <= lat_d;
         odata_q     <= odata_d;
         olen_q      <= olen_d;
         frame_cnt_q <= frame_cnt_d;
         // registered so the decoder stays in reset for the first
         // cycle after our own reset releases
         dec_reset_q <= (state_d != S_CLR);
      end
   end

   always_comb begin
      state_d     = state_q;
      dat_d       = dat_q;
      cnt_d       = cnt_q;
      lat_d       = lat_q;
      odata_d     = odata_q;
      olen_d      = olen_q;
      frame_cnt_d = frame_cnt_q;
      unique case (state_q)
         S_FILL: begin
            if (sym_valid) begin
               // pair k lands MSB-first at [2N-1-2k -: 2]
               for (int k = 0; k < N_BITS; k++) begin
                  if (cnt_q == LW'(k)) begin
                     dat_d[DW-1-2*k -: 2] = sym_data;
                  end
               end
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_PAIR || sym_last) begin
                  olen_d  = cnt_q + 1'b1;
                  state_d = S_CLR;
               end
            end
         end
         S_CLR: begin
            lat_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (lat_q == LAT_END) begin
               // bits beyond the received pairs decode from the
               // zero padding and carry no information
               odata_d = dec_out &
                         ~({N_BITS{1'b1}} >> olen_q);
               state_d = S_OUT;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         S_OUT: begin
            if (out_ready) begin
               frame_cnt_d = frame_cnt_q + 16'd1;
               cnt_d       = '0;
               dat_d       = '0;
               state_d     = S_FILL;
            end
         end
         default: state_d = S_FILL;
      endcase
   end

   assign sym_ready = (state_q == S_FILL);
   assign busy      = (state_q != S_FILL);
   assign dec_start = (state_q == S_WAIT);
   assign out_valid = (state_q == S_OUT);
   assign dec_reset = dec_reset_q;
   assign dec_dat   = dat_q;
   assign out_data  = odata_q;
   assign out_len   = olen_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// tb_viterbi_frame_ctrl: directed frames against a behavioural decoder
// stub, with a queue-based scoreboard checking every delivered frame.
module tb_viterbi_frame_ctrl;

   localparam int N   = 7;
   localparam int LAT = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sym_valid = 1'b0;
   logic [1:0]  sym_data = '0;
   logic        sym_last = 1'b0;
   logic        sym_ready;
   logic [13:0] dec_dat;
   logic        dec_start;
   logic        dec_reset;
   logic [6:0]  dec_out;
   logic        out_valid;
   logic [6:0]  out_data;
   logic [2:0]  out_len;
   logic        out_ready = 1'b0;
   logic        busy;
   logic [15:0] frame_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [6:0]  d;
      logic [2:0]  l;
      logic [13:0] dat;
      logic [15:0] fc;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   viterbi_frame_ctrl #(.N_BITS(N), .DEC_LAT(LAT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sym_valid (sym_valid),
      .sym_data  (sym_data),
      .sym_last  (sym_last),
      .sym_ready (sym_ready),
      .dec_dat   (dec_dat),
      .dec_start (dec_start),
      .dec_reset (dec_reset),
      .dec_out   (dec_out),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_len   (out_len),
      .out_ready (out_ready),
      .busy      (busy),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   // decoder stub: valid result only in the LAT-th cycle of ready
   int stub_cnt = 0;

   function automatic logic [6:0] stub_f(input logic [13:0] d);
      logic [6:0] r;
      for (int i = 0; i < 7; i++) r[i] = d[2*i+1];
      return r;
   endfunction

   always @(posedge clk or negedge dec_reset) begin
      if (!dec_reset || !dec_start) stub_cnt <= 0;
      else stub_cnt <= stub_cnt + 1;
   end

   always_comb begin
      dec_out = ~stub_f(dec_dat);
      if (dec_start && stub_cnt >= LAT - 1) dec_out = stub_f(dec_dat);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [6:0] d, input logic [2:0] l,
                       input logic [13:0] dat, input logic [15:0] fc);
      exp_t x;
      x.d = d; x.l = l; x.dat = dat; x.fc = fc;
      sb.push_back(x);
   endtask

   // monitor: compare on every output handshake
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_frame", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("sb_out_data", out_data, e.d);
            chk("sb_out_len", out_len, e.l);
            chk("sb_dec_dat", dec_dat, e.dat);
            chk("sb_frame_cnt", frame_cnt, e.fc);
         end
      end
   end

   task automatic send(input int n, input logic [13:0] pairs);
      int t;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         sym_valid = 1'b1;
         sym_data  = pairs[13-2*k -: 2];
         sym_last  = (k == n - 1);
         t = 0;
         while (!sym_ready && t < 60) begin
            @(negedge clk);
            t++;
         end
         chk("send_sym_ready", sym_ready, 1);
         @(posedge clk);
      end
      #1;
      sym_valid = 1'b0;
      sym_last  = 1'b0;
   endtask

   task automatic wait_hs();
      int t = 0;
      @(negedge clk);
      while (!(out_valid && out_ready) && t < 60) begin
         @(negedge clk);
         t++;
      end
      chk("handshake_seen", out_valid && out_ready, 1);
      @(posedge clk);
   endtask

   localparam logic [13:0] FRM_A = 14'h3D97;

   initial begin
      int rlow, st, ov, first, rfirst, t;
      logic [6:0] hold_d;

      // reset held with random inputs
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         sym_valid = 1'($urandom);
         sym_data  = 2'($urandom);
         sym_last  = 1'($urandom);
         out_ready = 1'($urandom);
         #1;
         chk("rst_ctrl",
             {sym_ready, dec_start, dec_reset, out_valid, busy},
             5'b10000);
         chk("rst_data", {dec_dat, out_data, out_len}, 0);
         chk("rst_frame_cnt", frame_cnt, 0);
      end
      @(negedge clk);
      sym_valid = 0; sym_last = 0; out_ready = 1;
      rst_n = 1;
      #1 chk("rst_release_dec_reset", dec_reset, 0);
      @(negedge clk);
      chk("post_rst_dec_reset", dec_reset, 1);
      chk("post_rst_sym_ready", sym_ready, 1);

      // full frame
      push(7'h69, 3'd7, FRM_A, 16'd0);
      send(7, FRM_A);
      wait_hs();
      #1;
      chk("full_frame_cnt", frame_cnt, 1);
      chk("full_dat_cleared", dec_dat, 0);

      // latency profile, out_ready held high
      push(7'h69, 3'd7, FRM_A, 16'd1);
      send(7, FRM_A);
      rlow = 0; st = 0; ov = 0; first = 0; rfirst = 0;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (!dec_reset) begin
            rlow++;
            if (rfirst == 0) rfirst = i;
         end
         if (dec_start) st++;
         if (out_valid) begin
            ov++;
            if (first == 0) first = i;
         end
      end
      chk("lat_clr_cycles", rlow, 1);
      chk("lat_clr_first", rfirst, 1);
      chk("lat_start_cycles", st, LAT);
      chk("lat_out_valid_at", first, LAT + 2);
      chk("lat_out_valid_cycles", ov, 1);

      // short frame 10,11,01
      push(7'h60, 3'd3, 14'h2D00, 16'd2);
      send(3, 14'b10_11_01_00000000);
      wait_hs();

      // backpressure
      @(posedge clk);
      #1 out_ready = 0;
      push(7'h69, 3'd7, FRM_A, 16'd3);
      send(7, FRM_A);
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 60) begin
         @(negedge clk);
         t++;
      end
      chk("bp_out_valid", out_valid, 1);
      sym_valid = 1; sym_data = 2'b01; sym_last = 0;
      hold_d = 7'h69;
      for (int i = 0; i < 5; i++) begin
         chk("bp_sym_ready", sym_ready, 0);
         chk("bp_out_data", out_data, hold_d);
         chk("bp_out_len", out_len, 7);
         chk("bp_frame_cnt", frame_cnt, 3);
         @(negedge clk);
      end
      push(7'h20, 3'd2, 14'h1C00, 16'd4);
      @(posedge clk);
      #1 out_ready = 1;
      @(posedge clk);
      #1 chk("bp_frame_cnt_inc", frame_cnt, 4);
      send(2, 14'b01_11_0000000000);
      wait_hs();

      // reset three cycles into WAIT
      send(7, FRM_A);
      repeat (4) @(posedge clk);
      #2 chk("midrst_pre_start", dec_start, 1);
      rst_n = 0;
      #1;
      chk("midrst_dec_start", dec_start, 0);
      chk("midrst_dec_reset", dec_reset, 0);
      chk("midrst_sym_ready", sym_ready, 1);
      chk("midrst_dec_dat", dec_dat, 0);
      chk("midrst_frame_cnt", frame_cnt, 0);
      @(negedge clk);
      rst_n = 1;
      push(7'h60, 3'd3, 14'h2D00, 16'd0);
      send(3, 14'b10_11_01_00000000);
      wait_hs();

      // frame counter wrap
      @(negedge clk);
      force dut.frame_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.frame_cnt_q;
      #1 chk("wrap_preset", frame_cnt, 16'hFFFF);
      push(7'h69, 3'd7, FRM_A, 16'hFFFF);
      send(7, FRM_A);
      wait_hs();
      #1 chk("wrap_frame_cnt", frame_cnt, 0);

      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
